// File: rtl/feistel_iter_core.sv
// feistel_iter_core
//
// Iterative Feistel block-cipher engine. The block is 64 bits, the key is 256 bits and each
// round uses a 16-bit subkey. The core applies one round per clock. Encrypt or decrypt is
// chosen per transaction. It sits between the data buffer and the output packer.
//
// Parameters
//   ROUNDS   number of Feistel rounds; legal range is 1..16.
//
// Ports
//   clk      system clock; all state updates happen on the rising edge.
//   rst_n    asynchronous active-low reset.
//   ivalid   upstream presents a block on idata/ikey/imode.
//   oready   core accepts a block on this edge when ivalid is also high.
//   idata    plaintext (encrypt) or ciphertext (decrypt).
//   ikey     key, sixteen 16-bit words k0..kf with k0 in [255:240] and kf in [15:0].
//   imode    0 = encrypt, 1 = decrypt.
//   ovalid   odata holds a finished result.
//   iready   downstream accepts odata.
//   odata    result block.
//   obusy    rounds are in progress.
//
// Notation
//   Kpre  = key[127:64]
//   Kpost = key[63:0]
//   SK(i) = key[255-16*i -: 16]
//   F(x,k) = rotl32(x + {k,k}, 5)
//
// Encryption
//   The input is pre-whitened with Kpre.
//   Round i uses SK(i).
//   The swapped halves are post-whitened with Kpost.
//
// Decryption
//   Decryption mirrors encryption.
//   The input is pre-whitened with Kpost.
//   Round i uses SK(ROUNDS-1-i).
//   The output is post-whitened with Kpre.

module feistel_iter_core #(
  parameter int unsigned ROUNDS = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ivalid,
  output logic         oready,
  input  logic [63:0]  idata,
  input  logic [255:0] ikey,
  input  logic         imode,
  output logic         ovalid,
  input  logic         iready,
  output logic [63:0]  odata,
  output logic         obusy
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  // Index of the final round.
  localparam logic [3:0] LastRnd = 4'(ROUNDS - 1);

  logic [1:0]   state_q, state_d;
  logic [31:0]  l_q, l_d;
  logic [31:0]  r_q, r_d;
  logic [255:0] key_q, key_d;
  logic         mode_q, mode_d;
  logic [3:0]   rnd_q, rnd_d;
  logic [63:0]  odata_q, odata_d;

  logic         accept;
  logic [63:0]  in_white;
  logic [63:0]  in_blk;
  logic [3:0]   sk_idx;
  logic [15:0]  subkey;
  logic [31:0]  f_sum;
  logic [31:0]  f_out;
  logic [31:0]  l_nxt;
  logic [31:0]  r_nxt;
  logic [63:0]  out_white;
  logic         last_rnd;

  // ---------------------------------------------------------------------------------------------
  // Handshake and status outputs
  // ---------------------------------------------------------------------------------------------

  // In DONE the core can take a new block on the same edge that the result leaves.
  assign oready = (state_q == StIdle) | ((state_q == StDone) & iready);
  assign accept = ivalid & oready;
  assign ovalid = (state_q == StDone);
  assign obusy  = (state_q == StRun);
  assign odata  = odata_q;

  // ---------------------------------------------------------------------------------------------
  // Input pre-whitening
  // ---------------------------------------------------------------------------------------------

  // Uses the live ikey/imode because this is the accept cycle.
  assign in_white = imode ? ikey[63:0] : ikey[127:64];
  assign in_blk   = idata ^ in_white;

  // ---------------------------------------------------------------------------------------------
  // Round datapath (works only on the captured key and mode)
  // ---------------------------------------------------------------------------------------------

  // Decrypt walks the subkeys in reverse.
  // LastRnd - rnd_q stays in 0..LastRnd because rnd_q never exceeds LastRnd.
  assign sk_idx = mode_q ? (LastRnd - rnd_q) : rnd_q;

  // Subkey i sits at bit offset 16*(15-i). For a 4-bit index, 15-i is the same as ~i.
  assign subkey = key_q[{~sk_idx, 4'b0000} +: 16];

  // Round function: a 32-bit add (carry discarded), then rotate left by 5.
  assign f_sum = r_q + {subkey, subkey};
  assign f_out = {f_sum[26:0], f_sum[31:27]};

  // One Feistel step: (L, R) <= (R, L ^ F(R, SK)).
  assign l_nxt = r_q;
  assign r_nxt = l_q ^ f_out;

  // Output post-whitening uses the opposite half of the key from pre-whitening.
  assign out_white = mode_q ? key_q[127:64] : key_q[63:0];
  assign last_rnd  = (rnd_q == LastRnd);

  // ---------------------------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------------------------

  always_comb begin
    state_d = state_q;
    l_d     = l_q;
    r_d     = r_q;
    key_d   = key_q;
    mode_d  = mode_q;
    rnd_d   = rnd_q;
    odata_d = odata_q;

    case (state_q)
      StIdle: begin
        // Stay idle until a block is offered.
      end

      StRun: begin
        l_d = l_nxt;
        r_d = r_nxt;
        if (last_rnd) begin
          // The final halves are swapped on output, then post-whitened.
          odata_d = {r_nxt, l_nxt} ^ out_white;
          state_d = StDone;
        end else begin
          rnd_d = rnd_q + 4'd1;
        end
      end

      StDone: begin
        // Leave DONE only when the result is taken.
        // An accept below can override this and go straight back to RUN.
        if (iready) begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase

    // A new block can arrive from IDLE, or from DONE as the old result leaves.
    if (accept) begin
      state_d = StRun;
      l_d     = in_blk[63:32];
      r_d     = in_blk[31:0];
      key_d   = ikey;
      mode_d  = imode;
      rnd_d   = 4'd0;
    end
  end

  // ---------------------------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------------------------

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      l_q     <= '0;
      r_q     <= '0;
      key_q   <= '0;
      mode_q  <= 1'b0;
      rnd_q   <= '0;
      odata_q <= '0;
    end else begin
      state_q <= state_d;
      l_q     <= l_d;
      r_q     <= r_d;
      key_q   <= key_d;
      mode_q  <= mode_d;
      rnd_q   <= rnd_d;
      odata_q <= odata_d;
    end
  end

endmodule

// File: tb/tb_feistel_iter_core.sv
module tb_feistel_iter_core;

  function automatic int unsigned rounds_of(input int g);
    case (g)
      0:       return 8;
      1:       return 1;
      2:       return 5;
      default: return 16;
    endcase
  endfunction

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         ivalid [4];
  logic         oready [4];
  logic [63:0]  idata  [4];
  logic [255:0] ikey   [4];
  logic         imode  [4];
  logic         ovalid [4];
  logic         iready [4];
  logic [63:0]  odata  [4];
  logic         obusy  [4];

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [1:0]  g;
    logic [63:0] d;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    feistel_iter_core #(
      .ROUNDS(rounds_of(g))
    ) u_dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .ivalid (ivalid[g]),
      .oready (oready[g]),
      .idata  (idata[g]),
      .ikey   (ikey[g]),
      .imode  (imode[g]),
      .ovalid (ovalid[g]),
      .iready (iready[g]),
      .odata  (odata[g]),
      .obusy  (obusy[g])
    );
  end

  // Independent reference model.
  function automatic logic [63:0] model(input int unsigned rounds, input logic [255:0] k,
                                        input logic m, input logic [63:0] d);
    logic [63:0] b;
    logic [31:0] l, r, t, f, tmp;
    logic [15:0] sk;
    int idx;
    b = d ^ (m ? k[63:0] : k[127:64]);
    l = b[63:32];
    r = b[31:0];
    for (int i = 0; i < int'(rounds); i++) begin
      idx = m ? int'(rounds) - 1 - i : i;
      sk  = k[255 - 16 * idx -: 16];
      t   = r + {sk, sk};
      f   = (t << 5) | (t >> 27);
      tmp = l ^ f;
      l   = r;
      r   = tmp;
    end
    return {r, l} ^ (m ? k[127:64] : k[63:0]);
  endfunction

  function automatic logic [255:0] rand_key();
    logic [255:0] k;
    for (int i = 0; i < 8; i++) k[i*32 +: 32] = $urandom;
    return k;
  endfunction

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: a transfer happens on the edge after a negedge with ovalid & iready.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int g = 0; g < 4; g++) begin
        if (ovalid[g] && iready[g]) begin
          total++;
          if (sb.size() == 0) begin
            bad++;
            $display("FAIL sb_unexpected inst%0d: got %h expected no output", g, odata[g]);
          end else begin
            mon_e = sb.pop_front();
            if (int'(mon_e.g) != g || odata[g] !== mon_e.d) begin
              bad++;
              $display("FAIL sb_out inst%0d: got %h expected %h (from inst%0d)",
                       g, odata[g], mon_e.d, mon_e.g);
            end
          end
        end
      end
    end
  end

  task automatic issue(input int g, input logic [63:0] d, input logic [255:0] k,
                       input logic m, input bit push, input logic [63:0] expv);
    int n;
    idata[g]  = d;
    ikey[g]   = k;
    imode[g]  = m;
    ivalid[g] = 1'b1;
    if (push) sb.push_back({2'(g), expv});
    n = 0;
    @(negedge clk);
    while (!oready[g] && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (n >= 100) begin
      total++;
      bad++;
      $display("FAIL issue_timeout inst%0d: got oready=0 expected 1", g);
    end
    @(posedge clk);
    #1;
    ivalid[g] = 1'b0;
  endtask

  // Counts rising edges from the accept edge until ovalid appears.
  task automatic wait_out(input int g, input int exp_lat, input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (!ovalid[g] && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (n >= 200) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got ovalid=0 expected 1", name);
    end else if (exp_lat >= 0) begin
      check64(name, 64'(n), 64'(exp_lat));
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] k, k2, k3;
    logic [63:0]  p, c, c2, c3;
    int unsigned  r;

    rst_n = 1'b0;
    for (int g = 0; g < 4; g++) begin
      ivalid[g] = 1'b0;
      iready[g] = 1'b1;
      imode[g]  = 1'b0;
      idata[g]  = '0;
      ikey[g]   = '0;
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    for (int g = 0; g < 4; g++) begin
      check64($sformatf("rst_oready%0d", g), 64'(oready[g]), 64'd1);
      check64($sformatf("rst_ovalid%0d", g), 64'(ovalid[g]), 64'd0);
      check64($sformatf("rst_obusy%0d", g), 64'(obusy[g]), 64'd0);
      check64($sformatf("rst_odata%0d", g), odata[g], 64'd0);
    end
    @(posedge clk);
    #1;

    // All-zero, 8 rounds.
    issue(0, 64'h0, 256'h0, 1'b0, 1'b1, 64'h0);
    wait_out(0, 8, "lat_zero");

    // Single round, hand-computed.
    issue(1, 64'h00000000_00000001, 256'h0, 1'b0, 1'b1, 64'h00000020_00000001);
    wait_out(1, 1, "lat_r1");

    // Round trips for ROUNDS = 8, 1, 5, 16.
    p = 64'h0123_4567_89AB_CDEF;
    for (int g = 0; g < 4; g++) begin
      r = rounds_of(g);
      k = rand_key();
      c = model(r, k, 1'b0, p);
      issue(g, p, k, 1'b0, 1'b1, c);
      wait_out(g, int'(r), $sformatf("lat_enc%0d", g));
      issue(g, c, k, 1'b1, 1'b1, p);
      wait_out(g, int'(r), $sformatf("lat_dec%0d", g));
    end

    // Backpressure, then back-to-back accept in DONE.
    k2 = rand_key();
    k3 = rand_key();
    c2 = model(8, k2, 1'b0, 64'hDEAD_BEEF_0BAD_F00D);
    c3 = model(8, k3, 1'b0, 64'h1111_2222_3333_4444);
    iready[0] = 1'b0;
    issue(0, 64'hDEAD_BEEF_0BAD_F00D, k2, 1'b0, 1'b1, c2);
    wait_out(0, 8, "lat_bp");
    idata[0]  = 64'h1111_2222_3333_4444;
    ikey[0]   = k3;
    imode[0]  = 1'b0;
    ivalid[0] = 1'b1;
    sb.push_back({2'd0, c3});
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check64($sformatf("bp_ovalid_c%0d", i), 64'(ovalid[0]), 64'd1);
      check64($sformatf("bp_odata_c%0d", i), odata[0], c2);
      check64($sformatf("bp_oready_c%0d", i), 64'(oready[0]), 64'd0);
      @(posedge clk);
      #1;
    end
    iready[0] = 1'b1;
    @(negedge clk);
    check64("b2b_oready", 64'(oready[0]), 64'd1);
    @(posedge clk);
    #1;
    ivalid[0] = 1'b0;
    wait_out(0, 8, "lat_b2b");

    // Input isolation during RUN (decrypt).
    k = rand_key();
    p = 64'hCAFE_F00D_1234_5678;
    issue(0, p, k, 1'b1, 1'b1, model(8, k, 1'b1, p));
    for (int i = 0; i < 5; i++) begin
      idata[0] = {$urandom, $urandom};
      ikey[0]  = rand_key();
      imode[0] = ~imode[0];
      @(posedge clk);
      #1;
    end
    wait_out(0, 3, "lat_iso");

    // Reset in the middle of a transaction.
    issue(0, 64'h5555_AAAA_5555_AAAA, rand_key(), 1'b0, 1'b0, 64'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check64("mid_obusy", 64'(obusy[0]), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    check64("rst_mid_ovalid", 64'(ovalid[0]), 64'd0);
    check64("rst_mid_obusy", 64'(obusy[0]), 64'd0);
    check64("rst_mid_odata", odata[0], 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check64("post_rst_oready", 64'(oready[0]), 64'd1);
    @(posedge clk);
    #1;
    k = rand_key();
    p = 64'h0F0F_0F0F_F0F0_F0F0;
    issue(0, p, k, 1'b0, 1'b1, model(8, k, 1'b0, p));
    wait_out(0, 8, "lat_post_rst");

    repeat (3) @(posedge clk);
    check64("sb_empty", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
